// File: rtl/maxunpool.sv
// 2x2 max-unpool: scatters each pooled value to its argmax slot, one window per cycle; start is ignored while busy.
// Optional MAXUNPOOL_NEAREST_EN adds a per-frame 'nearest' input that fills all four slots of each window.
module maxunpool #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int OUT_SIZE   = 28,
  parameter int POOL       = 2,
  localparam int IN_SIZE   = OUT_SIZE / POOL
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef MAXUNPOOL_NEAREST_EN
  input  logic                         nearest,
`endif
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] in_feature  [CHANNELS][IN_SIZE][IN_SIZE],
  input  logic [1:0]                   in_index    [CHANNELS][IN_SIZE][IN_SIZE],
  output logic signed [DATA_WIDTH-1:0] out_feature [CHANNELS][OUT_SIZE][OUT_SIZE],
  output logic                         busy,
  output logic                         done
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  if (POOL != 2) begin : g_pool_check
    $fatal(1, "maxunpool: only POOL=2 is supported");
  end

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] c;
  logic [IW-1:0] r, q;
  logic          q_last, r_last, c_last, last;

`ifdef MAXUNPOOL_NEAREST_EN
  logic nearest_q;
`else
  localparam logic nearest_q = 1'b0;
`endif

  assign q_last = (q == IW'(IN_SIZE - 1));
  assign r_last = (r == IW'(IN_SIZE - 1));
  assign c_last = (c == CW'(CHANNELS - 1));
  assign last   = c_last && r_last && q_last;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan counters: q fastest, then r, then c.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c    <= '0;
      r    <= '0;
      q    <= '0;
      done <= 1'b0;
`ifdef MAXUNPOOL_NEAREST_EN
      nearest_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            c <= '0;
            r <= '0;
            q <= '0;
`ifdef MAXUNPOOL_NEAREST_EN
            nearest_q <= nearest;
`endif
          end
        end
        RUN: begin
          if (q_last) begin
            q <= '0;
            if (r_last) begin
              r <= '0;
              c <= c + 1'b1;
            end else begin
              r <= r + 1'b1;
            end
          end else begin
            q <= q + 1'b1;
          end
        end
        FINISH:  done <= 1'b1;
        default: done <= 1'b0;
      endcase
    end
  end

  // Every window rewrites all four slots, so stale values from a previous frame
  // never survive; an odd trailing row/column is outside every window and stays 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < CHANNELS; ch++)
        for (int row = 0; row < OUT_SIZE; row++)
          for (int col = 0; col < OUT_SIZE; col++)
            out_feature[ch][row][col] <= '0;
    end else if (state == RUN) begin
      for (int ch = 0; ch < CHANNELS; ch++)
        for (int pr = 0; pr < IN_SIZE; pr++)
          for (int pq = 0; pq < IN_SIZE; pq++)
            if (c == CW'(ch) && r == IW'(pr) && q == IW'(pq))
              for (int k = 0; k < 4; k++)
                out_feature[ch][2*pr + k/2][2*pq + k%2] <=
                  (nearest_q || in_index[ch][pr][pq] == 2'(k)) ? in_feature[ch][pr][pq] : '0;
    end
  end

endmodule

// File: tb/tb_maxunpool.sv
// Directed bench for maxunpool: three small instances (1x4x4, 2x2x2, 1x5x5 outputs).
module tb_maxunpool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  logic signed [15:0] fa [1][2][2];
  logic [1:0]         ia [1][2][2];
  logic signed [15:0] oa [1][4][4];

  logic signed [15:0] fb [2][1][1];
  logic [1:0]         ib [2][1][1];
  logic signed [15:0] ob [2][2][2];

  logic signed [15:0] fc [1][2][2];
  logic [1:0]         ic [1][2][2];
  logic signed [15:0] oc [1][5][5];

`ifdef MAXUNPOOL_NEAREST_EN
  logic nearest_a;
`endif

  int total = 0;
  int bad   = 0;

  maxunpool #(.DATA_WIDTH(16), .CHANNELS(1), .OUT_SIZE(4), .POOL(2)) u_a (
    .clk(clk), .reset(reset),
`ifdef MAXUNPOOL_NEAREST_EN
    .nearest(nearest_a),
`endif
    .start(start_a), .in_feature(fa), .in_index(ia), .out_feature(oa),
    .busy(busy_a), .done(done_a));

  maxunpool #(.DATA_WIDTH(16), .CHANNELS(2), .OUT_SIZE(2), .POOL(2)) u_b (
    .clk(clk), .reset(reset),
`ifdef MAXUNPOOL_NEAREST_EN
    .nearest(1'b0),
`endif
    .start(start_b), .in_feature(fb), .in_index(ib), .out_feature(ob),
    .busy(busy_b), .done(done_b));

  maxunpool #(.DATA_WIDTH(16), .CHANNELS(1), .OUT_SIZE(5), .POOL(2)) u_c (
    .clk(clk), .reset(reset),
`ifdef MAXUNPOOL_NEAREST_EN
    .nearest(1'b0),
`endif
    .start(start_c), .in_feature(fc), .in_index(ic), .out_feature(oc),
    .busy(busy_c), .done(done_c));

  // Pulse start on one instance and count edges after the sampling edge until done.
  task automatic run_frame(input int sel, output int edges);
    logic d;
    case (sel)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    edges = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      edges++;
      case (sel)
        0:       d = done_a;
        1:       d = done_b;
        default: d = done_c;
      endcase
      if (d) break;
    end
  endtask

  task automatic test_reset();
    int edges;
    int pulses;
    reset = 1'b0;
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_a); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (oa[0][i][j] !== 16'sd0) begin
          bad++; $display("FAIL rst_out[%0d][%0d]: got %0d want 0", i, j, oa[0][i][j]);
        end
      end
    @(negedge clk);
    reset = 1'b1;
    fa = '{'{'{16'sd5, -16'sd3}, '{16'sd7, 16'sd100}}};
    ia = '{'{'{2'd0, 2'd1}, '{2'd2, 2'd3}}};
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    total++; if (oa[0][0][0] !== 16'sd5) begin bad++; $display("FAIL mid_write: got %0d want 5", oa[0][0][0]); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done_a); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (oa[0][i][j] !== 16'sd0) begin
          bad++; $display("FAIL abort_out[%0d][%0d]: got %0d want 0", i, j, oa[0][i][j]);
        end
      end
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_a) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    run_frame(0, edges);
    total++; if (edges != 5) begin bad++; $display("FAIL post_rst_latency: got %0d want 5", edges); end
    @(negedge clk);
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL post_rst_pulse: got %b want 0", done_a); end
  endtask

  task automatic test_index_routing();
    int edges;
    int e [4][4];
    fa = '{'{'{16'sd5, -16'sd3}, '{16'sd7, 16'sd100}}};
    ia = '{'{'{2'd0, 2'd1}, '{2'd2, 2'd3}}};
    e  = '{'{5, 0, 0, -3}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{7, 0, 0, 100}};
    run_frame(0, edges);
    total++; if (edges != 5) begin bad++; $display("FAIL idx_latency: got %0d want 5", edges); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (oa[0][i][j] !== 16'(e[i][j])) begin
          bad++; $display("FAIL idx_out[%0d][%0d]: got %0d want %0d", i, j, oa[0][i][j], e[i][j]);
        end
      end
    fa = '{'{'{16'sd1, 16'sd2}, '{16'sd3, 16'sd4}}};
    ia = '{'{'{2'd3, 2'd2}, '{2'd1, 2'd0}}};
    e  = '{'{0, 0, 0, 0}, '{0, 1, 2, 0}, '{0, 3, 4, 0}, '{0, 0, 0, 0}};
    run_frame(0, edges);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (oa[0][i][j] !== 16'(e[i][j])) begin
          bad++; $display("FAIL idx2_out[%0d][%0d]: got %0d want %0d", i, j, oa[0][i][j], e[i][j]);
        end
      end
  endtask

  task automatic test_multichannel();
    int edges;
    int pulses;
    logic signed [15:0] e [2][2][2];
    fb = '{'{'{16'sh8000}}, '{'{16'sh7FFF}}};
    ib = '{'{'{2'd3}}, '{'{2'd0}}};
    e  = '{'{'{16'sh0000, 16'sh0000}, '{16'sh0000, 16'sh8000}},
           '{'{16'sh7FFF, 16'sh0000}, '{16'sh0000, 16'sh0000}}};
    start_b = 1'b1;
    @(negedge clk);
    edges = 0;
    for (int k = 0; k < 50; k++) begin
      start_b = (edges < 2);
      @(negedge clk);
      edges++;
      if (done_b) break;
    end
    start_b = 1'b0;
    total++; if (edges != 3) begin bad++; $display("FAIL mc_latency: got %0d want 3", edges); end
    for (int ch = 0; ch < 2; ch++)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          total++;
          if (ob[ch][i][j] !== e[ch][i][j]) begin
            bad++; $display("FAIL mc_out[%0d][%0d][%0d]: got %0d want %0d", ch, i, j, ob[ch][i][j], e[ch][i][j]);
          end
        end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_b) pulses++;
      total++;
      if (busy_b !== 1'b0) begin bad++; $display("FAIL mc_no_requeue: got busy=%b want 0", busy_b); end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL mc_single_pulse: got %0d extra pulses want 0", pulses); end
  endtask

  task automatic test_odd_size();
    int edges;
    logic signed [15:0] want;
    fc = '{'{'{16'sd9, 16'sd9}, '{16'sd9, 16'sd9}}};
    ic = '{'{'{2'd0, 2'd0}, '{2'd0, 2'd0}}};
    run_frame(2, edges);
    total++; if (edges != 5) begin bad++; $display("FAIL odd_latency: got %0d want 5", edges); end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        want = (i % 2 == 0 && j % 2 == 0 && i < 4 && j < 4) ? 16'sd9 : 16'sd0;
        total++;
        if (oc[0][i][j] !== want) begin
          bad++; $display("FAIL odd_out[%0d][%0d]: got %0d want %0d", i, j, oc[0][i][j], want);
        end
      end
  endtask

  task automatic test_back_to_back();
    int edges;
    int e [4][4];
    fa = '{'{'{16'sd5, -16'sd3}, '{16'sd7, 16'sd100}}};
    ia = '{'{'{2'd0, 2'd1}, '{2'd2, 2'd3}}};
    e  = '{'{0, -1, 0, 2}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{-3, 0, 4, 0}};
    start_a = 1'b1;
    @(negedge clk);
    edges = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      edges++;
      if (done_a) break;
    end
    total++; if (edges != 5) begin bad++; $display("FAIL b2b_first_latency: got %0d want 5", edges); end
    fa = '{'{'{-16'sd1, 16'sd2}, '{-16'sd3, 16'sd4}}};
    ia = '{'{'{2'd1, 2'd1}, '{2'd2, 2'd2}}};
    @(negedge clk);
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL b2b_pulse1: got %b want 0", done_a); end
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL b2b_restart: got busy=%b want 1", busy_a); end
    edges = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      edges++;
      if (done_a) break;
    end
    start_a = 1'b0;
    total++; if (edges != 5) begin bad++; $display("FAIL b2b_second_latency: got %0d want 5", edges); end
    @(negedge clk);
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL b2b_pulse2: got %b want 0", done_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_idle: got busy=%b want 0", busy_a); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (oa[0][i][j] !== 16'(e[i][j])) begin
          bad++; $display("FAIL b2b_out[%0d][%0d]: got %0d want %0d", i, j, oa[0][i][j], e[i][j]);
        end
      end
  endtask

`ifdef MAXUNPOOL_NEAREST_EN
  task automatic test_nearest();
    int edges;
    int e [4][4];
    fa = '{'{'{16'sd1, 16'sd2}, '{16'sd3, 16'sd4}}};
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        ia[0][i][j] = 2'($urandom_range(0, 3));
    e = '{'{1, 1, 2, 2}, '{1, 1, 2, 2}, '{3, 3, 4, 4}, '{3, 3, 4, 4}};
    nearest_a = 1'b1;
    run_frame(0, edges);
    nearest_a = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (oa[0][i][j] !== 16'(e[i][j])) begin
          bad++; $display("FAIL near_out[%0d][%0d]: got %0d want %0d", i, j, oa[0][i][j], e[i][j]);
        end
      end
    ia = '{'{'{2'd0, 2'd1}, '{2'd2, 2'd3}}};
    e  = '{'{1, 0, 0, 2}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{3, 0, 0, 4}};
    run_frame(0, edges);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (oa[0][i][j] !== 16'(e[i][j])) begin
          bad++; $display("FAIL near_off_out[%0d][%0d]: got %0d want %0d", i, j, oa[0][i][j], e[i][j]);
        end
      end
  endtask
`endif

  initial begin
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
`ifdef MAXUNPOOL_NEAREST_EN
    nearest_a = 1'b0;
`endif
    fa = '{'{'{16'sd0, 16'sd0}, '{16'sd0, 16'sd0}}};
    ia = '{'{'{2'd0, 2'd0}, '{2'd0, 2'd0}}};
    fb = '{'{'{16'sd0}}, '{'{16'sd0}}};
    ib = '{'{'{2'd0}}, '{'{2'd0}}};
    fc = '{'{'{16'sd0, 16'sd0}, '{16'sd0, 16'sd0}}};
    ic = '{'{'{2'd0, 2'd0}, '{2'd0, 2'd0}}};
    test_reset();
    test_index_routing();
    test_multichannel();
    test_odd_size();
    test_back_to_back();
`ifdef MAXUNPOOL_NEAREST_EN
    test_nearest();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxunpool.md
Name: maxunpool

Overview:
- Inverse of the 2x2 max-pool stage.
- Takes a pooled feature map plus per-window argmax indices and scatters each pooled value back to its winning position in a full-resolution map; the other three positions in each window are zeroed.
- Sits after a max-pool stage in decoder or backward (gradient-routing) paths.
- Uses the same start/done frame handshake as the other layer blocks.

Parameters:
- DATA_WIDTH, 16, signed element width.
- CHANNELS, 8, number of feature channels.
- OUT_SIZE, 28, full-resolution output map side length.
- POOL, 2, window side. Only 2 is supported; elaboration fails (assertion) otherwise.
- IN_SIZE (localparam), OUT_SIZE/POOL, pooled input map side length.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame start request, sampled in IDLE only.
- in_feature  in  DATA_WIDTH signed x [CHANNELS][IN_SIZE][IN_SIZE]  pooled values.
- in_index  in  2 x [CHANNELS][IN_SIZE][IN_SIZE]  argmax position within each 2x2 window.
- out_feature  out  DATA_WIDTH signed x [CHANNELS][OUT_SIZE][OUT_SIZE]  unpooled map.
- busy  out  1  high while in RUN or FINISH.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; done=0; busy=0; counters c, r, q = 0.
  - Every out_feature element = 0.
  - Reset mid-frame aborts immediately, and no done pulse follows.
- States: IDLE, RUN, FINISH.
- IDLE:
  - done<=0.
  - On start=1: c, r, q<=0; state<=RUN.
- RUN: one pooled element per cycle at (c, r, q). The 2x2 window at rows 2r..2r+1, cols 2q..2q+1 is written in the same cycle:
  - Index encoding: 0=(2r,2q), 1=(2r,2q+1), 2=(2r+1,2q), 3=(2r+1,2q+1).
  - The indexed position gets in_feature[c][r][q]; the other three get 0.
- Scan order: q fastest, then r, then c.
  - q wraps at IN_SIZE-1, which increments r.
  - r wraps at IN_SIZE-1, which increments c.
  - At c=CHANNELS-1, r=q=IN_SIZE-1, state<=FINISH after the write.
- FINISH: done<=1 for exactly one cycle; state<=IDLE.
- Latency:
  - start sampled at edge 0.
  - Writes occur on edges 1..N, where N=CHANNELS*IN_SIZE*IN_SIZE.
  - done is high in the cycle after edge N+1; busy is high from edge 1 through edge N+1.
- Handshakes and inputs:
  - start is ignored while busy; no queueing.
  - start held high across done re-triggers a new frame on the first IDLE cycle.
  - Inputs are read live, so in_feature and in_index must be held stable from start until done.
- Odd OUT_SIZE: the last row and column are never written and keep the value from reset (0).
- out_feature holds its last frame's values until overwritten; it is not cleared between frames.
- Arithmetic: pure data routing; values pass bit-exact, with no saturation or sign change.

Optional Feature:
- Macro: MAXUNPOOL_NEAREST_EN.
- Defined:
  - Adds input port nearest (1 bit), sampled together with start and latched for the whole frame.
  - When latched high, every window's four positions receive in_feature[c][r][q] and in_index is ignored (nearest-neighbour upsample).
  - When latched low, behaviour is the indexed scatter above.
- Not defined: no nearest port; indexed scatter only.

Test Plan:
- Reset check: CHANNELS=1, OUT_SIZE=4; pulse reset low mid-frame -> out_feature all 0, done=0, busy=0; next start completes normally with done after exactly N+1=5 edges.
- Index routing: CHANNELS=1, OUT_SIZE=4; in_feature={{5,-3},{7,100}}, in_index={{0,1},{2,3}} -> out rows {5,0,0,-3},{0,0,0,0},{0,0,0,0},{7,0,0,100}.
- Multi-channel and handshake: CHANNELS=2, OUT_SIZE=2; ch0=-32768 idx3, ch1=32767 idx0 -> out[0]={{0,0},{0,-32768}}, out[1]={{32767,0},{0,0}}; done single pulse at edge 3; start pulses during busy ignored.
- Odd size: OUT_SIZE=5, CHANNELS=1; all pooled values 9, idx 0 -> out[0][0],[0][2],[2][0],[2][2]=9; row 4 and col 4 remain 0.
- Back-to-back frames: start held high -> second frame begins the cycle after done; out reflects second frame's data; done pulses twice, each for one cycle.
- MAXUNPOOL_NEAREST_EN: nearest=1, OUT_SIZE=4, in_feature={{1,2},{3,4}}, random indices -> out rows {1,1,2,2},{1,1,2,2},{3,3,4,4},{3,3,4,4}; nearest=0 on the next frame restores indexed scatter.
